// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//
// Holds a parallel 8-bit word on the data bus of a downstream 8:1 mux and
// walks the mux select across all eight positions, REPEAT times per word,
// one position per accepted bit (valid/ready handshake on the bit side).
//
// Parameters
//   REPEAT      number of full 8-bit scans per loaded word (1..4)
//
// Build option
//   MSB_FIRST_EN  undefined: sel runs 0 -> 7 (LSB first)
//                 defined:   sel runs 7 -> 0 (MSB first); also sets the
//                            reset value of sel to 7
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         word to be scanned
//   load_valid  din is valid
//   load_ready  block can accept a word (IDLE)
//   d           held word, drives the downstream mux data bus
//   sel         mux select
//   y           local copy of d[sel]
//   bit_valid   y/sel hold a valid scan bit (SCAN)
//   bit_ready   consumer accepts the current bit
//   bit_last    current bit is the final bit of the final repeat
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a word; load_ready=1, bit_valid=0
// SCAN  | presenting d[sel]; sel advances on each bit_ready edge

module mux_scan_sequencer #(
    parameter int REPEAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       load_valid,
    output logic       load_ready,
    output logic [7:0] d,
    output logic [2:0] sel,
    output logic       y,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_last
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

`ifdef MSB_FIRST_EN
    localparam logic [2:0] SEL_START = 3'd7;
    localparam logic [2:0] SEL_END   = 3'd0;
`else
    localparam logic [2:0] SEL_START = 3'd0;
    localparam logic [2:0] SEL_END   = 3'd7;
`endif

    // Repeat counter is sized for the largest legal REPEAT (4).
    localparam logic [1:0] REP_LAST = 2'(REPEAT - 1);

    logic [0:0] state;
    logic [1:0] rep_cnt;
    logic [2:0] sel_step;
    logic       at_end;
    logic       last_rep;

`ifdef MSB_FIRST_EN
    assign sel_step = sel - 3'd1;
`else
    assign sel_step = sel + 3'd1;
`endif

    assign at_end   = (sel == SEL_END);
    assign last_rep = (rep_cnt == REP_LAST);

    assign load_ready = (state == IDLE);
    assign bit_valid  = (state == SCAN);
    assign bit_last   = bit_valid && at_end && last_rep;
    // d is cleared by reset, so y reads 0 while rst_n is low.
    assign y          = d[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            d       <= 8'h00;
            sel     <= SEL_START;
            rep_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        d       <= din;
                        sel     <= SEL_START;
                        rep_cnt <= 2'd0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    // din/load_valid are deliberately not looked at here so
                    // the mux data bus cannot change under the consumer.
                    if (bit_ready) begin
                        if (!at_end) begin
                            sel <= sel_step;
                        end else if (!last_rep) begin
                            rep_cnt <= rep_cnt + 2'd1;
                            sel     <= SEL_START;
                        end else begin
                            sel   <= SEL_START;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//
// Drives two instances: u_rep1 (REPEAT=1) and u_rep2 (REPEAT=2). Expected
// bits (sel, y, bit_last) are queued when a word is loaded and compared
// each cycle the DUT presents a valid bit; an entry is retired only when
// bit_ready is high, so stalled cycles must repeat the same bit.

module tb_mux_scan_sequencer;

    typedef struct packed {
        logic [2:0] sel;
        logic       y;
        logic       last;
    } exp_t;

`ifdef MSB_FIRST_EN
    localparam bit MSB = 1'b1;
    localparam logic [2:0] START = 3'd7;
`else
    localparam bit MSB = 1'b0;
    localparam logic [2:0] START = 3'd0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] din        [2];
    logic       load_valid [2];
    logic       load_ready [2];
    logic [7:0] d          [2];
    logic [2:0] sel        [2];
    logic       y          [2];
    logic       bit_valid  [2];
    logic       bit_ready  [2];
    logic       bit_last   [2];

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] cur_word [2];

    int checks = 0;
    int errors = 0;

    mux_scan_sequencer #(.REPEAT(1)) u_rep1 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .load_valid(load_valid[0]),
        .load_ready(load_ready[0]), .d(d[0]), .sel(sel[0]), .y(y[0]),
        .bit_valid(bit_valid[0]), .bit_ready(bit_ready[0]), .bit_last(bit_last[0])
    );

    mux_scan_sequencer #(.REPEAT(2)) u_rep2 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .load_valid(load_valid[1]),
        .load_ready(load_ready[1]), .d(d[1]), .sel(sel[1]), .y(y[1]),
        .bit_valid(bit_valid[1]), .bit_ready(bit_ready[1]), .bit_last(bit_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitors: sample mid-cycle, retire on handshake.
    always @(negedge clk) begin
        if (rst_n && bit_valid[0]) begin
            if (q0.size() == 0) begin
                chk("rep1_unexpected_bit", 32'd1, 32'd0);
            end else begin
                chk("rep1_sel", 32'(sel[0]), 32'(q0[0].sel));
                chk("rep1_y", 32'(y[0]), 32'(q0[0].y));
                chk("rep1_last", 32'(bit_last[0]), 32'(q0[0].last));
                chk("rep1_d", 32'(d[0]), 32'(cur_word[0]));
                chk("rep1_load_ready", 32'(load_ready[0]), 32'd0);
                if (bit_ready[0]) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bit_valid[1]) begin
            if (q1.size() == 0) begin
                chk("rep2_unexpected_bit", 32'd1, 32'd0);
            end else begin
                chk("rep2_sel", 32'(sel[1]), 32'(q1[0].sel));
                chk("rep2_y", 32'(y[1]), 32'(q1[0].y));
                chk("rep2_last", 32'(bit_last[1]), 32'(q1[0].last));
                chk("rep2_d", 32'(d[1]), 32'(cur_word[1]));
                chk("rep2_load_ready", 32'(load_ready[1]), 32'd0);
                if (bit_ready[1]) void'(q1.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_load_ready"}, 32'(load_ready[i]), 32'd1);
            chk({tag, "_bit_valid"}, 32'(bit_valid[i]), 32'd0);
            chk({tag, "_bit_last"}, 32'(bit_last[i]), 32'd0);
            chk({tag, "_sel"}, 32'(sel[i]), 32'(START));
            chk({tag, "_d"}, 32'(d[i]), 32'd0);
            chk({tag, "_y"}, 32'(y[i]), 32'd0);
        end
    endtask

    // Load one word into instance i and run the scan to completion.
    // stall_sel/stall_n: hold bit_ready low for stall_n cycles when sel hits
    // stall_sel. inject: keep load_valid/din=FF asserted during the scan.
    // abort_pos >= 0: pull rst_n low once that many bits have been accepted.
    task automatic run(input int i, input logic [7:0] w, input int reps,
                       input int stall_sel, input int stall_n, input bit inject,
                       input int abort_pos, input int exp_cyc);
        int   wait_cyc;
        int   cyc;
        int   stalled;
        int   accepted;
        exp_t e;
        wait_cyc = 0;
        @(negedge clk);
        while (!load_ready[i] && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("load_ready_wait", 32'(load_ready[i]), 32'd1);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < 8; k++) begin
                e.sel  = MSB ? 3'(7 - k) : 3'(k);
                e.y    = w[e.sel];
                e.last = (r == reps - 1) && (k == 7);
                if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
        cur_word[i]   = w;
        din[i]        = w;
        load_valid[i] = 1'b1;
        bit_ready[i]  = 1'b1;
        @(posedge clk);
        #1;
        load_valid[i] = 1'b0;
        chk("accept_latency", 32'(bit_valid[i]), 32'd1);
        cyc      = 0;
        stalled  = 0;
        accepted = 0;
        while (bit_valid[i] && cyc < 200) begin
            if (abort_pos >= 0 && accepted == abort_pos) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("abort_bit_valid", 32'(bit_valid[i]), 32'd0);
                chk("abort_sel", 32'(sel[i]), 32'(START));
                chk("abort_d", 32'(d[i]), 32'd0);
                chk("abort_y", 32'(y[i]), 32'd0);
                q0.delete();
                q1.delete();
                #1;
                rst_n = 1'b1;
                bit_ready[i] = 1'b0;
                return;
            end
            if (inject) begin
                load_valid[i] = 1'b1;
                din[i]        = 8'hFF;
            end
            if (int'(sel[i]) == stall_sel && stalled < stall_n) begin
                bit_ready[i] = 1'b0;
                stalled++;
            end else begin
                bit_ready[i] = 1'b1;
                accepted++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        load_valid[i] = 1'b0;
        bit_ready[i]  = 1'b0;
        chk("scan_cycles", 32'(cyc), 32'(exp_cyc));
        chk("idle_load_ready", 32'(load_ready[i]), 32'd1);
        chk("idle_sel", 32'(sel[i]), 32'(START));
        chk("idle_d_held", 32'(d[i]), 32'(w));
        chk("queue_drained", (i == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            din[i] = 8'h00; load_valid[i] = 1'b0; bit_ready[i] = 1'b0;
            cur_word[i] = 8'h00;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        #11;
        check_reset_outputs("reset_held");
        rst_n = 1'b1;

        run(0, 8'b10101010, 1, -1, 0, 1'b0, -1, 8);
        run(0, 8'b10101010, 1, MSB ? 5 : 2, 3, 1'b0, -1, 11);
        run(0, 8'h0F, 1, -1, 0, 1'b1, -1, 8);
        run(1, 8'hC3, 2, -1, 0, 1'b0, -1, 16);
        run(1, 8'h5A, 2, 3, 2, 1'b0, -1, 18);
        run(0, 8'h96, 1, MSB ? 0 : 7, 1, 1'b0, -1, 9);

        // Abort mid-scan, then the next word must be taken straight away.
        run(0, 8'h5A, 1, -1, 0, 1'b0, 4, 0);
        check_reset_outputs("post_abort");
        run(0, 8'h3C, 1, -1, 0, 1'b0, -1, 8);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have parameter REPEAT, default 1, which sets how many full 8-bit scans each loaded word receives (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port din, input, 8 bits: parallel word to be scanned.
REQ-005 The block SHALL have port load_valid, input, 1 bit: din is valid.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port d, output, 8 bits: the held word, which drives the downstream 8:1 mux data bus.
REQ-008 The block SHALL have port sel, output, 3 bits: the mux select, which drives the downstream 8:1 mux select.
REQ-009 The block SHALL have port y, output, 1 bit: the local copy of d[sel], combinational.
REQ-010 The block SHALL have port bit_valid, output, 1 bit: y/sel hold a valid scan bit.
REQ-011 The block SHALL have port bit_ready, input, 1 bit: the consumer accepts the current bit.
REQ-012 The block SHALL have port bit_last, output, 1 bit: the current bit is the final bit of the final repeat.

Function
REQ-013 The block SHALL implement two states: IDLE and SCAN.
REQ-014 In IDLE, load_ready SHALL be 1 and bit_valid SHALL be 0.
REQ-015 In SCAN, load_ready SHALL be 0 and bit_valid SHALL be 1.
REQ-016 On an edge with load_valid=1 and load_ready=1, the block SHALL:
- capture din into d;
- set sel to START;
- clear the repeat counter to 0;
- enter SCAN, with bit_valid high the next cycle (1-cycle latency).
REQ-017 On an edge in SCAN with bit_ready=1 and sel!=END, sel SHALL step one position toward END.
REQ-018 On an edge in SCAN with bit_ready=1, sel==END and repeat counter<REPEAT-1, the block SHALL increment the repeat counter and set sel to START.
REQ-019 On an edge in SCAN with bit_ready=1, sel==END and repeat counter==REPEAT-1, the block SHALL return to IDLE; sel SHALL be set to START and d SHALL hold its value.
REQ-020 With bit_ready=0 in SCAN, sel, d and the repeat counter SHALL hold; y SHALL stay stable.
REQ-021 bit_last SHALL equal bit_valid AND sel==END AND repeat counter==REPEAT-1.
REQ-022 In SCAN, load_valid and din SHALL be ignored; d SHALL never change mid-scan.
REQ-023 With bit_ready held at 1, one word SHALL occupy 8*REPEAT SCAN cycles plus 1 IDLE cycle before the next acceptance; there is no back-to-back load.
REQ-024 sel SHALL never wrap past END; wrap occurs only via the explicit reload to START.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL hold:
- state=IDLE, d=8'h00, sel=START, repeat counter=0;
- bit_valid=0, bit_last=0, load_ready=1, y=0.
REQ-026 rst_n asserted mid-scan SHALL abort the word immediately with no further bits.
REQ-027 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-028 The macro MSB_FIRST_EN SHALL select the scan order.
- Undefined: START=0, END=7, sel increments (LSB first).
- Defined: START=7, END=0, sel decrements (MSB first).
- The macro SHALL affect the reset value of sel identically.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- REPEAT=1, macro undefined, load 8'b10101010, bit_ready=1: sel=0..7 on consecutive cycles; y=0,1,0,1,0,1,0,1; bit_last only with sel=7; load_ready=1 on the following cycle.
- Same load with bit_ready=0 for 3 cycles while sel=2: sel stays 2 and y stays 0 for 3 cycles, then the scan resumes at sel=3; total 11 SCAN cycles.
- Assert load_valid with din=8'hFF during a scan of 8'h0F: d stays 8'h0F and y never deviates from 8'h0F bits.
- REPEAT=2, load 8'hC3: 16 SCAN cycles with y=1,1,0,0,0,0,1,1 twice; bit_last only on cycle 16.
- Pull rst_n low at sel=4 of a scan: bit_valid=0, sel=0, d=8'h00 immediately, without waiting for a clock edge.
- MSB_FIRST_EN defined, load 8'b10101010: reset sel=7; sel=7..0; y=1,0,1,0,1,0,1,0; bit_last with sel=0.
